// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC-register feedback, redirect, imem req/gnt/rvalid and
// decode valid/ready. master = fetch unit, slave = its surroundings.
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] curr_pc;
  logic [XLEN-1:0] next_pc;
  logic            pc_en;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_ready;

  modport master (
    input  curr_pc, redirect_valid, redirect_pc, imem_gnt, imem_rvalid,
           imem_rdata, if_ready,
    output next_pc, pc_en, imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output curr_pc, redirect_valid, redirect_pc, imem_gnt, imem_rvalid,
           imem_rdata, if_ready,
    input  next_pc, pc_en, imem_req, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: imem req/gnt/rvalid to decode valid/ready; gnt->if_valid 2 cycles min.
// Backpressure: requests stop once outstanding+buffered reaches DEPTH; redirect flushes.
module instr_fetch #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  // Discards are not bounded by DEPTH (back-to-back redirects), only by what
  // the memory can hold in flight; a few spare bits cover that.
  localparam int DW = AW + 4;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  // One ring holds every live fetch: [rd,fill) returned, [fill,wr) granted.
  logic [AW:0]     wr_ptr, fill_ptr, rd_ptr;
  logic [DW-1:0]   disc_cnt;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [AW:0] pend_cnt, occ, occ_after_pop;
  logic        pop, credit, accept, drop, fill;

  assign pend_cnt      = wr_ptr - fill_ptr;
  assign occ           = wr_ptr - rd_ptr;
  assign pop           = bus.if_valid && bus.if_ready;
  assign occ_after_pop = occ - {{AW{1'b0}}, pop};
  assign credit        = occ_after_pop < DEPTH_W;

  assign bus.imem_req  = credit && !bus.redirect_valid && !rst;
  assign bus.imem_addr = bus.curr_pc;
  assign accept        = bus.imem_req && bus.imem_gnt;

  assign drop = bus.imem_rvalid && (disc_cnt != '0);
  assign fill = bus.imem_rvalid && (disc_cnt == '0);

  assign bus.pc_en   = accept || bus.redirect_valid;
  assign bus.next_pc = bus.redirect_valid ? (bus.redirect_pc & ~XLEN'(3))
                                          : bus.curr_pc + XLEN'(4);

  assign bus.if_valid = fill_ptr != rd_ptr;
  assign bus.if_pc    = pc_mem[rd_ptr[AW-1:0]];
  assign bus.if_instr = instr_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      disc_cnt <= '0;
    end else if (bus.redirect_valid) begin
      // Flush beats any same-cycle pop or fill; in-flight grants become discards.
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      disc_cnt <= disc_cnt + DW'(pend_cnt) - DW'(bus.imem_rvalid);
    end else begin
      if (accept) wr_ptr   <= wr_ptr + 1'b1;
      if (fill)   fill_ptr <= fill_ptr + 1'b1;
      if (pop)    rd_ptr   <= rd_ptr + 1'b1;
      if (drop)   disc_cnt <= disc_cnt - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pc_mem[wr_ptr[AW-1:0]]      <= bus.curr_pc;
    if (fill)   instr_mem[fill_ptr[AW-1:0]] <= bus.imem_rdata;
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: PC register and in-order memory modelled
// here; expected decode stream is the list of PCs granted since the last flush.
module tb_instr_fetch;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.XLEN(32)) bus ();
  instr_fetch #(.XLEN(32), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;
  int n_pop  = 0;
  int n_acc  = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mq_addr[$];
  int          mq_cyc[$];

  logic        pend_en, held, redir_prev, last_pop, last_rv;
  logic [31:0] pend_npc, held_pc, held_instr, last_pop_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic cycle(input int p_gnt, input int p_rv, input int p_rdy,
                       input logic redir, input logic [31:0] rpc);
    logic pop, acc, exp_req;
    int   occ;
    @(negedge clk);
    cyc++;
    if (pend_en) bus.curr_pc = pend_npc;
    bus.imem_gnt = ($urandom_range(99) < p_gnt);
    if (mq_addr.size() > 0 && mq_cyc[0] < cyc && $urandom_range(99) < p_rv) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_cyc.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.if_ready       = ($urandom_range(99) < p_rdy);
    #1;
    pop     = bus.if_valid && bus.if_ready;
    acc     = bus.imem_req && bus.imem_gnt;
    occ     = exp_q.size() - (pop ? 1 : 0);
    exp_req = !redir && (occ < DEPTH);
    chk("imem_req", bus.imem_req, exp_req);
    if (bus.imem_req) chk("imem_addr", bus.imem_addr, bus.curr_pc);
    chk("pc_en", bus.pc_en, redir || (exp_req && bus.imem_gnt));
    if (redir) chk("next_pc_redir", bus.next_pc, rpc & 32'hFFFF_FFFC);
    else if (bus.pc_en) chk("next_pc_seq", bus.next_pc, bus.curr_pc + 32'd4);
    if (redir_prev) chk("flush_empty", bus.if_valid, 1'b0);
    else if (held) begin
      chk("hold_valid", bus.if_valid, 1'b1);
      chk("hold_pc", bus.if_pc, held_pc);
      chk("hold_instr", bus.if_instr, held_instr);
    end
    if (exp_q.size() == 0) chk("empty_valid", bus.if_valid, 1'b0);
    last_pop = pop;
    last_rv  = bus.imem_rvalid;
    if (pop && !redir && exp_q.size() > 0) begin
      chk("if_pc", bus.if_pc, exp_q[0]);
      chk("if_instr", bus.if_instr, mem_word(exp_q[0]));
      last_pop_pc = bus.if_pc;
      n_pop++;
      void'(exp_q.pop_front());
    end
    if (redir) exp_q.delete();
    else if (acc) exp_q.push_back(bus.curr_pc);
    if (acc) begin
      n_acc++;
      mq_addr.push_back(bus.curr_pc);
      mq_cyc.push_back(cyc);
    end
    held       = bus.if_valid && !bus.if_ready && !redir;
    held_pc    = bus.if_pc;
    held_instr = bus.if_instr;
    redir_prev = redir;
    pend_en    = bus.pc_en;
    pend_npc   = bus.next_pc;
  endtask

  // Reset lands mid-cycle so its effect on outputs is visibly asynchronous.
  task automatic do_reset(input logic [31:0] pc);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_if_valid", bus.if_valid, 1'b0);
    chk("rst_imem_req", bus.imem_req, 1'b0);
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.if_ready       = 1'b0;
    bus.curr_pc        = pc;
    #1;
    chk("rst_pc_en", bus.pc_en, 1'b0);
    exp_q.delete();
    mq_addr.delete();
    mq_cyc.delete();
    pend_en    = 1'b0;
    held       = 1'b0;
    redir_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n0, a0, p_g, p_r, p_y;
    bus.curr_pc = '0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.if_ready = 1'b0;
    pend_en = 1'b0; held = 1'b0; redir_prev = 1'b0; last_pop_pc = '0;
    do_reset(32'h0);

    // Full-rate stream: first instruction two cycles after the first grant.
    n0 = n_pop;
    repeat (20) cycle(100, 100, 100, 1'b0, 0);
    chk("stream_pops", n_pop - n0, 18);

    // Decode stalled: exactly DEPTH grants, then in-order drain.
    do_reset(32'h0);
    a0 = n_acc;
    repeat (10) cycle(100, 100, 0, 1'b0, 0);
    chk("stall_grants", n_acc - a0, DEPTH);
    chk("stall_head_pc", bus.if_pc, 32'h0);
    repeat (10) cycle(100, 100, 100, 1'b0, 0);

    // Grant withheld: request and address held steady.
    do_reset(32'h0);
    cycle(0, 100, 100, 1'b1, 32'h100);
    repeat (3) begin
      cycle(0, 100, 100, 1'b0, 0);
      chk("gnt_wait_req", bus.imem_req, 1'b1);
      chk("gnt_wait_addr", bus.imem_addr, 32'h100);
      chk("gnt_wait_pc_en", bus.pc_en, 1'b0);
    end

    // Redirect with two grants outstanding: stale words dropped.
    do_reset(32'h0);
    repeat (2) cycle(100, 0, 100, 1'b0, 0);
    cycle(100, 0, 100, 1'b1, 32'h203);
    chk("redir_next_pc", bus.next_pc, 32'h200);
    n0 = n_pop;
    for (int i = 0; i < 20 && n_pop == n0; i++) cycle(100, 100, 100, 1'b0, 0);
    chk("redir_popped", n_pop > n0, 1'b1);
    chk("redir_first_pc", last_pop_pc, 32'h200);

    // Redirect coincident with a response and a pop.
    repeat (10) cycle(100, 100, 100, 1'b0, 0);
    cycle(100, 100, 100, 1'b1, 32'h400);
    chk("coinc_pop_rv", {last_pop, last_rv}, 2'b11);
    repeat (10) cycle(100, 100, 100, 1'b0, 0);

    // Address wrap at the top of the space.
    cycle(0, 100, 100, 1'b1, 32'hFFFF_FFFC);
    cycle(100, 100, 100, 1'b0, 0);
    chk("wrap_pc_en", bus.pc_en, 1'b1);
    chk("wrap_next_pc", bus.next_pc, 32'h0);
    repeat (8) cycle(100, 100, 100, 1'b0, 0);

    // Random traffic, handshake rates reshuffled every 100 cycles.
    for (int blk = 0; blk < 30; blk++) begin
      p_g = $urandom_range(100, 20);
      p_r = $urandom_range(100, 20);
      p_y = $urandom_range(100, 10);
      for (int i = 0; i < 100; i++)
        cycle(p_g, p_r, p_y, ($urandom_range(99) < 3), $urandom);
    end

    // Reset in the middle of a full-rate stream.
    repeat (10) cycle(100, 100, 100, 1'b0, 0);
    chk("pre_rst_valid", bus.if_valid, 1'b1);
    do_reset(32'h80);
    n0 = n_pop;
    repeat (10) cycle(100, 100, 100, 1'b0, 0);
    chk("post_rst_pops", n_pop - n0, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
